serial_nibble_adder: RTL
========================

// Module: serial_nibble_adder
// PURPOSE
//  Multi-cycle wide adder built around a 4-bit carry-lookahead nibble stage.
//  Accepts WIDTH-bit operands over a valid/ready handshake and adds one nibble
//  per clock, LSB nibble first. The nibble carry-out is registered into the
//  next nibble's carry-in. Returns sum, carry-out and signed overflow over a
//  valid/ready handshake. Sits between the operand source and the result
//  consumer.
// PARAMETERS
//  NIBBLES  4  number of 4-bit nibbles; WIDTH = 4*NIBBLES (16 by default); >=1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      operand request valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A, unsigned or two's complement
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in to nibble 0
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  a+b+cin, modulo 2^WIDTH
//  cout       out  1      carry out of MSB
//  ovf        out  1      signed overflow = carry into MSB ^ cout
//  busy       out  1      high in ADD or DONE
// BEHAVIOUR
//  Reset (async, any state):
//   - Forces state=IDLE, nibble index=0, carry reg=0.
//   - Clears sum=0, cout=0, ovf=0, out_valid=0 and busy=0; in_ready=1.
//   - An operation in flight is discarded; no result is emitted.
//  FSM: IDLE -> ADD -> DONE -> IDLE.
//   IDLE:
//    - in_ready=1.
//    - On in_valid&&in_ready: register a, b and cin; set idx=0; go to ADD.
//   ADD:
//    - in_ready=0.
//    - Each edge computes {c,s} = a[4*idx+:4] + b[4*idx+:4] + carry (5-bit
//      result), writes s into sum[4*idx+:4], sets carry<=c, idx<=idx+1.
//    - On the edge with idx==NIBBLES-1: cout<=c, ovf<=c ^ (MSB-bit carry-in),
//      out_valid<=1, go to DONE.
//   DONE:
//    - out_valid=1. sum, cout and ovf are stable.
//    - in_valid is ignored (in_ready=0).
//    - On out_valid&&out_ready: out_valid<=0, go to IDLE.
//  Result visibility:
//   - sum/cout/ovf keep their value after the handshake until the next
//     operation begins writing them.
//   - sum bits are only meaningful while out_valid=1.
//  Latency:
//   - out_valid rises exactly NIBBLES edges after the accepting edge.
//   - Minimum period is NIBBLES+2 cycles per operation; the block does not
//     accept back-to-back operations.
//  Boundary rules:
//   - Back-pressure: out_ready may stay low indefinitely; the result holds.
//   - The carry chain spans all nibbles (0xFFFF+1 ripples through every
//     nibble).
//   - NIBBLES=1 gives a single ADD cycle.
//   - The idx counter never exceeds NIBBLES-1; no wrap-around occurs.
//   - Operand inputs are sampled only on the accepting edge; later changes to
//     them have no effect.
// TESTING (NIBBLES=4)
//  1. rst pulse mid-idle -> sum=0, cout=0, ovf=0, out_valid=0, in_ready=1
//     immediately (async).
//  2. a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0; out_valid
//     exactly 4 edges after accept.
//  3. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
//     a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0.
//  4. a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
//     a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
//  5. out_ready low 5 cycles in DONE, in_valid=1 with new operands ->
//     out_valid held, sum stable, in_ready=0, new operands not taken.
//  6. rst asserted during ADD at idx=2 -> IDLE at once, out_valid never
//     rises; the next op a=0x0F0F, b=0x00F1 -> sum=0x1000, cout=0.

Source files
------------

// File: rtl/serial_nibble_adder.sv
// serial_nibble_adder: WIDTH-bit adder that adds one carry-lookahead nibble per clock, LSB nibble first,
// with valid/ready handshakes on operands and result.
module serial_nibble_adder #(
    parameter int NIBBLES = 4,
    localparam int WIDTH = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             cout_q, ovf_q, out_valid_q;
    logic [3:0]       na, nb, g, p, s_d;
    logic [4:0]       c_d;

    assign na = a_q[{idx_q, 2'b00} +: 4];
    assign nb = b_q[{idx_q, 2'b00} +: 4];
    assign g  = na & nb;
    assign p  = na ^ nb;
    // c_d[3] is the carry into the nibble's top bit, which on the last nibble is the MSB carry-in used for ovf
    assign c_d = {
        g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & carry_q),
        g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q),
        g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q),
        g[0] | (p[0] & carry_q),
        carry_q
    };
    assign s_d = p ^ c_d[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= b;
                    carry_q <= cin;
                    idx_q   <= '0;
                    state_q <= ADD;
                end
                ADD: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= s_d;
                    carry_q <= c_d[4];
                    if (idx_q == LAST) begin
                        cout_q      <= c_d[4];
                        ovf_q       <= c_d[4] ^ c_d[3];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule
